// File: rtl/param_register_file_pkg.sv
// Shared types and default sizing for the parameterised register file.
// The clear-sweep FSM states live here so that the top and the sub-module agree on them.
package rf_pkg;

  localparam int RF_DEFAULT_DW = 8;
  localparam int RF_DEFAULT_AW = 3;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/param_register_file_if.sv
// Bus interface of the register file: write port, dual read port with immediate, and clear request.
// The master side drives the requests, and the slave side returns the registered read results and busy.
interface param_register_file_if
  import rf_pkg::*;
#(
  parameter int DW = RF_DEFAULT_DW,
  parameter int AW = RF_DEFAULT_AW
);

  logic          regWrite;
  logic [AW-1:0] writeRegister;
  logic [DW-1:0] writeData;
  logic          readEnable;
  logic [AW-1:0] readRegister1;
  logic [AW-1:0] readRegister2;
  logic          immediate;
  logic [DW-1:0] immValue;
  logic          clearReq;
  logic          busy;
  logic          readValid;
  logic [DW-1:0] readData1;
  logic [DW-1:0] readData2;

  modport master (
    output regWrite, writeRegister, writeData, readEnable,
           readRegister1, readRegister2, immediate, immValue, clearReq,
    input  busy, readValid, readData1, readData2
  );

  modport slave (
    input  regWrite, writeRegister, writeData, readEnable,
           readRegister1, readRegister2, immediate, immValue, clearReq,
    output busy, readValid, readData1, readData2
  );

endinterface

// File: rtl/param_register_file_clear_fsm.sv
// Clear-sweep controller: owns the IDLE/CLEAR state, the AW-bit sweep address and the busy flag.
// While busy, the storage zeroes one register per cycle at sweepAddr_o, in ascending order.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int AW = RF_DEFAULT_AW
) (
  input  logic          clock,
  input  logic          resetN,
  input  logic          clearReq_i,
  output logic          busy_o,
  output logic [AW-1:0] sweepAddr_o
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  rf_state_e     state_q;
  logic [AW-1:0] sweepCnt_q;
  logic          busy_q;

  // The sweep ends on the last address itself, so the counter never wraps into an extra write.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= RF_IDLE;
      sweepCnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (clearReq_i) begin
            state_q    <= RF_CLEAR;
            sweepCnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        RF_CLEAR: begin
          if (sweepCnt_q == LAST_ADDR) begin
            state_q    <= RF_IDLE;
            sweepCnt_q <= '0;
            busy_q     <= 1'b0;
          end else begin
            sweepCnt_q <= sweepCnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= RF_IDLE;
          sweepCnt_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign sweepAddr_o = sweepCnt_q;

endmodule

// File: rtl/param_register_file.sv
// Flop-array register file with one write port, two registered read ports (write-first bypass),
// an immediate override on port 2, optional hardwired-zero r0, and a one-register-per-cycle clear sweep.
module param_register_file
  import rf_pkg::*;
#(
  parameter int DW       = RF_DEFAULT_DW,
  parameter int AW       = RF_DEFAULT_AW,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                 clock,
  input  logic                 resetN,
  param_register_file_if.slave bus
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] regFile_q [DEPTH];
  logic          readValid_q;
  logic [DW-1:0] readData1_q;
  logic [DW-1:0] readData2_q;
  logic [DW-1:0] readData1_d;
  logic [DW-1:0] readData2_d;
  logic          busy;
  logic [AW-1:0] sweepAddr;
  logic          writeEn;
  logic          readEn;

  rf_clear_fsm #(.AW(AW)) u_clearFsm (
    .clock       (clock),
    .resetN      (resetN),
    .clearReq_i  (bus.clearReq),
    .busy_o      (busy),
    .sweepAddr_o (sweepAddr)
  );

  assign writeEn = bus.regWrite && !busy && !(ZERO_REG && (bus.writeRegister == '0));
  assign readEn  = bus.readEnable && !busy;

  // writeEn already excludes a hardwired r0, so that address is never bypassed.
  always_comb begin
    readData1_d = regFile_q[bus.readRegister1];
    if (writeEn && (bus.writeRegister == bus.readRegister1)) begin
      readData1_d = bus.writeData;
    end
    if (ZERO_REG && (bus.readRegister1 == '0)) begin
      readData1_d = '0;
    end

    readData2_d = regFile_q[bus.readRegister2];
    if (writeEn && (bus.writeRegister == bus.readRegister2)) begin
      readData2_d = bus.writeData;
    end
    if (ZERO_REG && (bus.readRegister2 == '0)) begin
      readData2_d = '0;
    end
    if (bus.immediate) begin
      readData2_d = bus.immValue;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (busy) begin
      regFile_q[sweepAddr] <= '0;
    end else if (writeEn) begin
      regFile_q[bus.writeRegister] <= bus.writeData;
    end
  end

  // Read data only moves on an accepted read, so it holds between results.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      readValid_q <= 1'b0;
      readData1_q <= '0;
      readData2_q <= '0;
    end else begin
      readValid_q <= readEn;
      if (readEn) begin
        readData1_q <= readData1_d;
        readData2_q <= readData2_d;
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.readValid = readValid_q;
  assign bus.readData1 = readData1_q;
  assign bus.readData2 = readData2_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: an 8x8 instance with writable r0 and a 32x16 instance
// with hardwired r0, checked against hand-computed values.
module tb_param_register_file;

  logic clock;
  logic resetN;
  int   errorCount = 0;
  int   checkCount = 0;
  int   sweepCycles;
  int   validSeen;

  param_register_file_if #(.DW(8),  .AW(3)) busA ();
  param_register_file_if #(.DW(16), .AW(5)) busB ();

  param_register_file #(.DW(8), .AW(3), .ZERO_REG(1'b0)) dutA (
    .clock  (clock),
    .resetN (resetN),
    .bus    (busA)
  );

  param_register_file #(.DW(16), .AW(5), .ZERO_REG(1'b1)) dutB (
    .clock  (clock),
    .resetN (resetN),
    .bus    (busB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setIdle();
    busA.regWrite = 1'b0; busA.writeRegister = '0; busA.writeData = '0;
    busA.readEnable = 1'b0; busA.readRegister1 = '0; busA.readRegister2 = '0;
    busA.immediate = 1'b0; busA.immValue = '0; busA.clearReq = 1'b0;
    busB.regWrite = 1'b0; busB.writeRegister = '0; busB.writeData = '0;
    busB.readEnable = 1'b0; busB.readRegister1 = '0; busB.readRegister2 = '0;
    busB.immediate = 1'b0; busB.immValue = '0; busB.clearReq = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one cycle of requests on the selected instance (0 = A, 1 = B), then returns it to idle.
  task automatic applyStimulus(input bit sel, input bit we, input logic [7:0] wa, input logic [15:0] wd,
                               input bit re, input logic [7:0] ra1, input logic [7:0] ra2,
                               input bit imm, input logic [15:0] iv, input bit clr);
    if (!sel) begin
      busA.regWrite = we; busA.writeRegister = wa[2:0]; busA.writeData = wd[7:0];
      busA.readEnable = re; busA.readRegister1 = ra1[2:0]; busA.readRegister2 = ra2[2:0];
      busA.immediate = imm; busA.immValue = iv[7:0]; busA.clearReq = clr;
    end else begin
      busB.regWrite = we; busB.writeRegister = wa[4:0]; busB.writeData = wd;
      busB.readEnable = re; busB.readRegister1 = ra1[4:0]; busB.readRegister2 = ra2[4:0];
      busB.immediate = imm; busB.immValue = iv; busB.clearReq = clr;
    end
    tick();
    setIdle();
  endtask

  // Counts busy cycles while hammering the instance with requests that must be dropped.
  task automatic sweepCount(input bit sel, output int cycles, output int rvSeen);
    cycles = 0;
    rvSeen = 0;
    while ((sel ? busB.busy : busA.busy) && cycles < 100) begin
      cycles++;
      if (!sel) begin
        busA.regWrite = 1'b1; busA.writeRegister = 3'd1; busA.writeData = 8'hAB;
        busA.readEnable = 1'b1; busA.clearReq = 1'b1;
      end else begin
        busB.regWrite = 1'b1; busB.writeRegister = 5'd1; busB.writeData = 16'hABCD;
        busB.readEnable = 1'b1; busB.clearReq = 1'b1;
      end
      tick();
      if (sel ? busB.readValid : busA.readValid) rvSeen++;
    end
    setIdle();
  endtask

  initial begin
    resetN = 1'b0;
    setIdle();
    #2;
    checkOutput("rst_busyA",  busA.busy,      1'b0);
    checkOutput("rst_validA", busA.readValid, 1'b0);
    checkOutput("rst_rd1A",   busA.readData1, 8'h00);
    checkOutput("rst_rd2A",   busA.readData2, 8'h00);
    checkOutput("rst_busyB",  busB.busy,      1'b0);
    @(negedge clock);
    resetN = 1'b1;

    // Basic write then read, one-cycle valid, data hold.
    applyStimulus(0, 1, 3, 16'h5A, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 3, 3, 0, 0, 0);
    checkOutput("rd_validA", busA.readValid, 1'b1);
    checkOutput("rd_r3_p1",  busA.readData1, 8'h5A);
    checkOutput("rd_r3_p2",  busA.readData2, 8'h5A);
    tick();
    checkOutput("valid_drop", busA.readValid, 1'b0);
    checkOutput("hold_p1",    busA.readData1, 8'h5A);

    // Bypass on port 1 with immediate on port 2, then bypass on both ports.
    applyStimulus(0, 1, 2, 16'h33, 1, 2, 7, 1, 16'h0F, 0);
    checkOutput("byp_p1",  busA.readData1, 8'h33);
    checkOutput("imm_p2",  busA.readData2, 8'h0F);
    applyStimulus(0, 1, 4, 16'h44, 1, 4, 4, 0, 0, 0);
    checkOutput("byp2_p1", busA.readData1, 8'h44);
    checkOutput("byp2_p2", busA.readData2, 8'h44);

    // Fill r0..r7 with 0x11..0x88 and spot-check both ends.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 8'(i), 16'((i + 1) * 8'h11), 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
    checkOutput("fill_r0", busA.readData1, 8'h11);
    checkOutput("fill_r7", busA.readData2, 8'h88);

    // Clear together with a write (r5) and a read of r5/r6: write completes, read sees pre-clear data.
    applyStimulus(0, 1, 5, 16'h99, 1, 5, 6, 0, 0, 1);
    checkOutput("clr_rdvalid", busA.readValid, 1'b1);
    checkOutput("clr_rd_r5",   busA.readData1, 8'h99);
    checkOutput("clr_rd_r6",   busA.readData2, 8'h77);
    sweepCount(0, sweepCycles, validSeen);
    checkOutput("sweep_busyA",  sweepCycles, 8);
    checkOutput("sweep_validA", validSeen,   0);
    checkOutput("sweep_doneA",  busA.busy,   1'b0);
    for (int i = 0; i < 8; i += 2) begin
      applyStimulus(0, 0, 0, 0, 1, 8'(i), 8'(i + 1), 0, 0, 0);
      checkOutput($sformatf("post_clr_r%0d", i),     busA.readData1, 8'h00);
      checkOutput($sformatf("post_clr_r%0d", i + 1), busA.readData2, 8'h00);
    end

    // Reset in the third sweep cycle aborts the sweep and clears everything.
    applyStimulus(0, 1, 6, 16'h66, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 7, 16'h77, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6, 7, 0, 0, 1);
    checkOutput("pre_rst_r6", busA.readData1, 8'h66);
    checkOutput("pre_rst_busy", busA.busy, 1'b1);
    tick();
    tick();
    resetN = 1'b0;
    #1;
    checkOutput("midrst_busy",  busA.busy,      1'b0);
    checkOutput("midrst_valid", busA.readValid, 1'b0);
    checkOutput("midrst_rd1",   busA.readData1, 8'h00);
    checkOutput("midrst_rd2",   busA.readData2, 8'h00);
    @(negedge clock);
    resetN = 1'b1;
    tick();
    checkOutput("postrst_busy", busA.busy, 1'b0);
    applyStimulus(0, 0, 0, 0, 1, 6, 7, 0, 0, 0);
    checkOutput("postrst_r6", busA.readData1, 8'h00);
    checkOutput("postrst_r7", busA.readData2, 8'h00);

    // Wide instance with hardwired r0.
    applyStimulus(1, 1, 0, 16'h00FF, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("zr_validB", busB.readValid, 1'b1);
    checkOutput("zr_r0_p1",  busB.readData1, 16'h0000);
    applyStimulus(1, 1, 0, 16'h1234, 1, 0, 0, 0, 0, 0);
    checkOutput("zr_nobyp_p1", busB.readData1, 16'h0000);
    checkOutput("zr_nobyp_p2", busB.readData2, 16'h0000);
    applyStimulus(1, 1, 31, 16'hBEEF, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 31, 31, 0, 0, 0);
    checkOutput("wide_r31_p1", busB.readData1, 16'hBEEF);
    checkOutput("wide_r31_p2", busB.readData2, 16'hBEEF);
    applyStimulus(1, 0, 0, 0, 1, 31, 31, 1, 16'h1234, 0);
    checkOutput("wide_imm_p2", busB.readData2, 16'h1234);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    sweepCount(1, sweepCycles, validSeen);
    checkOutput("sweep_busyB",  sweepCycles, 32);
    checkOutput("sweep_validB", validSeen,   0);
    applyStimulus(1, 0, 0, 0, 1, 31, 1, 0, 0, 0);
    checkOutput("wide_clr_r31", busB.readData1, 16'h0000);
    checkOutput("wide_clr_r1",  busB.readData2, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter DW, default 8, data width in bits (legal 1..64).
REQ-002 Parameter AW, default 3, address width; depth DEPTH = 2**AW (legal AW 1..8).
REQ-003 Parameter ZERO_REG, default 0, when 1 register 0 is hardwired to zero.
REQ-004 Port clock, input, 1, sole clock; all state changes on rising edge.
REQ-005 Port resetN, input, 1, asynchronous active-low reset.
REQ-006 Port regWrite, input, 1, write enable.
REQ-007 Port writeRegister, input, AW, write address.
REQ-008 Port writeData, input, DW, write data.
REQ-009 Port readEnable, input, 1, read request for both read ports.
REQ-010 Port readRegister1, input, AW, port-1 read address.
REQ-011 Port readRegister2, input, AW, port-2 read address.
REQ-012 Port immediate, input, 1, selects immValue in place of port-2 register data.
REQ-013 Port immValue, input, DW, immediate operand.
REQ-014 Port clearReq, input, 1, single-cycle request to zero all registers.
REQ-015 Port busy, output, 1, high while a clear sweep is in progress.
REQ-016 Port readValid, output, 1, readData1/readData2 hold a new result this cycle.
REQ-017 Port readData1, output, DW, registered port-1 data.
REQ-018 Port readData2, output, DW, registered port-2 data or immediate.

Function
REQ-019 Read latency SHALL be 1 cycle: readEnable sampled high at edge N in IDLE -> readValid=1 and data valid after edge N, for exactly one cycle per request.
REQ-020 readData1/readData2 SHALL hold their last value when readValid=0.
REQ-021 Write SHALL update writeRegister at the edge where regWrite=1 in IDLE.
REQ-022 Same-cycle write and read of one address SHALL return writeData (write-first bypass), independently per port.
REQ-023 immediate=1 SHALL make readData2=immValue; bypass on port 2 does not apply.
REQ-024 ZERO_REG=1: reads of address 0 SHALL return 0, writes to address 0 are dropped, no bypass of address 0.
REQ-025 FSM states IDLE and CLEAR; IDLE->CLEAR on clearReq=1; CLEAR->IDLE after the write to address DEPTH-1.
REQ-026 CLEAR SHALL zero one register per cycle, addresses 0..DEPTH-1 ascending; busy=1 for exactly DEPTH cycles starting the cycle after clearReq.
REQ-027 In CLEAR, regWrite, readEnable and clearReq SHALL be ignored (dropped, not queued); readValid=0.
REQ-028 clearReq with regWrite in the same IDLE cycle: the write SHALL complete, then the sweep zeroes it.
REQ-029 clearReq with readEnable in the same IDLE cycle: the read SHALL be served with pre-clear data.
REQ-030 Sweep counter SHALL be AW bits and terminate on DEPTH-1 without wrap-induced extra writes.

Reset
REQ-031 resetN=0 SHALL asynchronously zero all registers, readData1, readData2, readValid, busy, sweep counter and force IDLE.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep; after release the block is in IDLE with all registers 0.
REQ-033 Reset deassertion SHALL be assumed synchronous to clock by the surrounding system; no internal synchroniser.

Structure
REQ-034 Package rf_pkg SHALL hold the FSM state enum (RF_IDLE, RF_CLEAR) and default DW/AW constants.
REQ-035 Sub-module rf_clear_fsm SHALL own the state, sweep counter and busy; storage and read muxing stay in the top.
REQ-036 Storage SHALL be a flop array (no memory macro); no $display in synthesizable code.

Verification
REQ-037 Write 0x5A to r3, then read r3/r3 -> readValid one cycle later, readData1=readData2=0x5A.
REQ-038 Same cycle write r2=0x33 and read r2,r7 with immediate=1, immValue=0x0F -> readData1=0x33, readData2=0x0F.
REQ-039 ZERO_REG=1: write r0=0xFF, read r0 -> 0x00.
REQ-040 Fill r0..r7 with 0x11..0x88, pulse clearReq -> busy high 8 cycles, writes/reads during sweep dropped, all reads afterwards 0x00.
REQ-041 Assert resetN=0 at sweep cycle 3 -> busy=0, readValid=0 immediately; after release all registers read 0.
REQ-042 DW=16, AW=5: write 0xBEEF to r31, read -> 0xBEEF; clear -> busy exactly 32 cycles.
